ahb_master_arbiter: RTL and testbench
=====================================

AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1: 1 = alternate grant on contention, 0 = fixed priority to dat master.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width of all ports.
REQ-003 SHALL have `clock  in  1`: single clock; all state changes on its rising edge.
REQ-004 SHALL have `reset  in  1`: synchronous, active-high.
REQ-005 SHALL have `ins_HADDR / dat_HADDR  in  ADDR_WIDTH`: master address.
REQ-006 SHALL have `ins_HTRANS / dat_HTRANS  in  2`: master transfer type.
REQ-007 SHALL have `ins_HWRITE / dat_HWRITE  in  1`: master write flag.
REQ-008 SHALL have `ins_HSIZE / dat_HSIZE  in  3`: master transfer size.
REQ-009 SHALL have `ins_HBURST / dat_HBURST  in  3`: master burst type; ignored.
REQ-010 SHALL have `ins_HPROT / dat_HPROT  in  4`: master protection.
REQ-011 SHALL have `ins_HWDATA / dat_HWDATA  in  32`: master write data.
REQ-012 SHALL have `ins_HRDATA / dat_HRDATA  out  32`: read data to the master.
REQ-013 SHALL have `ins_HREADY / dat_HREADY  out  1`: ready to the master.
REQ-014 SHALL have `ins_HRESP / dat_HRESP  out  1`: response to the master.
REQ-015 SHALL have `mem_HADDR, mem_HTRANS, mem_HWRITE, mem_HSIZE, mem_HBURST, mem_HPROT, mem_HWDATA  out`: shared slave bus; same widths as the master inputs.
REQ-016 SHALL have `mem_HMASTLOCK  out  1`: lock to slave; tied 0.
REQ-017 SHALL have `mem_HRDATA  in  32`, `mem_HREADY  in  1`, `mem_HRESP  in  1`: slave response.

Function
REQ-018 SHALL treat HTRANS[1]=1 (NONSEQ/SEQ) as a request; IDLE and BUSY are non-requests.
REQ-019 SHALL keep, per master, a hold register: valid, HADDR, HWRITE, HSIZE, HPROT.
REQ-020 SHALL keep state dphase_owner in {NONE, INS, DAT}; it changes only at edges where mem_HREADY=1.
REQ-021 SHALL drive master x HREADY as:
  - 0 while hold_valid_x=1;
  - mem_HREADY when dphase_owner=x;
  - 1 otherwise.
REQ-022 SHALL mark master x live-requesting when x HREADY=1 and x HTRANS[1]=1.
REQ-023 SHALL, when mem_HREADY=1, grant one of: held requests, live requests.
  - Both masters requesting, ROUND_ROBIN=1: grant the master not granted last.
  - Both requesting, ROUND_ROBIN=0: grant DAT.
REQ-024 SHALL, when mem_HREADY=0, make no grant, and drive the mem address phase from a valid hold register (DAT hold first); otherwise drive mem_HTRANS=IDLE.
REQ-025 SHALL drive the granted transfer on mem_*:
  - mem_HTRANS=NONSEQ, mem_HBURST=SINGLE;
  - other fields from the hold register if valid, else from live inputs.
REQ-026 SHALL, at an edge where master x is live-requesting and not granted with mem_HREADY=1, capture its address phase into hold_x and set hold_valid_x.
REQ-027 SHALL clear hold_valid_x at the edge where its held transfer is granted with mem_HREADY=1.
REQ-028 SHALL, at edges with mem_HREADY=1, set dphase_owner to the granted master, or NONE if no grant.
REQ-029 SHALL update the last-grant register on every grant.
REQ-030 SHALL mux mem_HWDATA from the dphase_owner's HWDATA; ins when NONE.
REQ-031 SHALL drive both ins_HRDATA and dat_HRDATA from mem_HRDATA.
REQ-032 SHALL drive x HRESP = mem_HRESP when dphase_owner=x, else 0.
REQ-033 SHALL give zero added latency to an uncontended granted transfer.
REQ-034 SHALL give a held transfer +1 cycle per competing transfer ahead of it.
REQ-035 SHALL never issue two transfers from the same master out of order.
REQ-036 SHALL never drop an accepted transfer.
REQ-037 SHALL have no combinational path from mem_HREADY to mem_HTRANS other than the hold/live select.

Reset
REQ-038 SHALL, when reset=1 at an edge, clear both hold_valid, set dphase_owner=NONE, and set last-grant=INS.
REQ-039 SHALL drive these outputs while in reset: mem_HTRANS=IDLE, ins/dat_HREADY=1, HRESP=0.
REQ-040 SHALL discard held transfers on reset mid-operation; no completion is signalled for them.

Verification
REQ-041 SHALL cover uncontended: ins NONSEQ read 0x100, mem_HREADY=1 -> mem_HADDR=0x100 in same cycle; ins_HREADY=1 next cycle with mem_HRDATA.
REQ-042 SHALL cover simultaneous, ROUND_ROBIN=1, after reset:
  - stimulus: ins 0x200, dat 0x8000 in same cycle;
  - response: dat issued first; ins held (ins_HREADY=0) and issued next cycle at 0x200.
REQ-043 SHALL cover slave wait:
  - stimulus: dat write 0x10, slave inserts 2 wait states, ins requests during the wait;
  - response: ins captured; mem_HADDR holds ins address, stable until mem_HREADY=1; dat_HREADY=0 for 2 cycles.
REQ-044 SHALL cover ROUND_ROBIN=0, continuous requests from both masters for 4 cycles -> all grants DAT; ins stays held.
REQ-045 SHALL cover error: slave 2-cycle HRESP=1 on an ins transfer -> ins_HRESP=1 for both cycles; dat_HRESP=0.
REQ-046 SHALL cover reset asserted while ins is held -> next cycle ins_HREADY=1, mem_HTRANS=IDLE, no issue of 0x200.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: merges instruction and data masters onto one slave bus,
// parking the loser's address phase in a hold register until it can be issued.
module ahb_master_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] ins_HADDR,
    input  logic [1:0]            ins_HTRANS,
    input  logic                  ins_HWRITE,
    input  logic [2:0]            ins_HSIZE,
    input  logic [2:0]            ins_HBURST,
    input  logic [3:0]            ins_HPROT,
    input  logic [31:0]           ins_HWDATA,
    output logic [31:0]           ins_HRDATA,
    output logic                  ins_HREADY,
    output logic                  ins_HRESP,

    input  logic [ADDR_WIDTH-1:0] dat_HADDR,
    input  logic [1:0]            dat_HTRANS,
    input  logic                  dat_HWRITE,
    input  logic [2:0]            dat_HSIZE,
    input  logic [2:0]            dat_HBURST,
    input  logic [3:0]            dat_HPROT,
    input  logic [31:0]           dat_HWDATA,
    output logic [31:0]           dat_HRDATA,
    output logic                  dat_HREADY,
    output logic                  dat_HRESP,

    output logic [ADDR_WIDTH-1:0] mem_HADDR,
    output logic [1:0]            mem_HTRANS,
    output logic                  mem_HWRITE,
    output logic [2:0]            mem_HSIZE,
    output logic [2:0]            mem_HBURST,
    output logic [3:0]            mem_HPROT,
    output logic [31:0]           mem_HWDATA,
    output logic                  mem_HMASTLOCK,
    input  logic [31:0]           mem_HRDATA,
    input  logic                  mem_HREADY,
    input  logic                  mem_HRESP
);

    localparam logic [1:0] OWNER_NONE   = 2'd0;
    localparam logic [1:0] OWNER_INS    = 2'd1;
    localparam logic [1:0] OWNER_DAT    = 2'd2;
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [2:0] BURST_SINGLE = 3'b000;

    logic [1:0]            r_owner;
    logic                  r_lastGrantDat;

    logic                  r_insHoldValid;
    logic [ADDR_WIDTH-1:0] r_insHoldAddr;
    logic                  r_insHoldWrite;
    logic [2:0]            r_insHoldSize;
    logic [3:0]            r_insHoldProt;

    logic                  r_datHoldValid;
    logic [ADDR_WIDTH-1:0] r_datHoldAddr;
    logic                  r_datHoldWrite;
    logic [2:0]            r_datHoldSize;
    logic [3:0]            r_datHoldProt;

    logic w_insReady;
    logic w_datReady;
    logic w_insLive;
    logic w_datLive;
    logic w_insWant;
    logic w_datWant;
    logic w_grantIns;
    logic w_grantDat;
    logic w_unusedInputs;

    // Bursts are always re-issued as SINGLE and HTRANS[0] never matters.
    assign w_unusedInputs = ^{ins_HBURST, dat_HBURST, ins_HTRANS[0], dat_HTRANS[0]};

    // A parked master is stalled; the data-phase owner follows the slave.
    always_comb begin
        w_insReady = 1'b1;
        w_datReady = 1'b1;
        if (!reset) begin
            if (r_insHoldValid)
                w_insReady = 1'b0;
            else if (r_owner == OWNER_INS)
                w_insReady = mem_HREADY;
            if (r_datHoldValid)
                w_datReady = 1'b0;
            else if (r_owner == OWNER_DAT)
                w_datReady = mem_HREADY;
        end
    end

    assign ins_HREADY = w_insReady;
    assign dat_HREADY = w_datReady;

    assign w_insLive = w_insReady & ins_HTRANS[1];
    assign w_datLive = w_datReady & dat_HTRANS[1];
    assign w_insWant = r_insHoldValid | w_insLive;
    assign w_datWant = r_datHoldValid | w_datLive;

    always_comb begin
        w_grantIns = 1'b0;
        w_grantDat = 1'b0;
        if (mem_HREADY && !reset) begin
            if (w_insWant && w_datWant) begin
                if (ROUND_ROBIN != 0 && r_lastGrantDat)
                    w_grantIns = 1'b1;
                else
                    w_grantDat = 1'b1;
            end else if (w_insWant) begin
                w_grantIns = 1'b1;
            end else if (w_datWant) begin
                w_grantDat = 1'b1;
            end
        end
    end

    // While the slave stalls, a parked request is presented so it is stable when accepted.
    always_comb begin
        mem_HTRANS = TRANS_IDLE;
        mem_HADDR  = r_insHoldAddr;
        mem_HWRITE = r_insHoldWrite;
        mem_HSIZE  = r_insHoldSize;
        mem_HPROT  = r_insHoldProt;
        if (reset) begin
            mem_HTRANS = TRANS_IDLE;
        end else if (w_grantIns) begin
            mem_HTRANS = TRANS_NONSEQ;
            if (!r_insHoldValid) begin
                mem_HADDR  = ins_HADDR;
                mem_HWRITE = ins_HWRITE;
                mem_HSIZE  = ins_HSIZE;
                mem_HPROT  = ins_HPROT;
            end
        end else if (w_grantDat) begin
            mem_HTRANS = TRANS_NONSEQ;
            if (r_datHoldValid) begin
                mem_HADDR  = r_datHoldAddr;
                mem_HWRITE = r_datHoldWrite;
                mem_HSIZE  = r_datHoldSize;
                mem_HPROT  = r_datHoldProt;
            end else begin
                mem_HADDR  = dat_HADDR;
                mem_HWRITE = dat_HWRITE;
                mem_HSIZE  = dat_HSIZE;
                mem_HPROT  = dat_HPROT;
            end
        end else if (!mem_HREADY) begin
            if (r_datHoldValid) begin
                mem_HTRANS = TRANS_NONSEQ;
                mem_HADDR  = r_datHoldAddr;
                mem_HWRITE = r_datHoldWrite;
                mem_HSIZE  = r_datHoldSize;
                mem_HPROT  = r_datHoldProt;
            end else if (r_insHoldValid) begin
                mem_HTRANS = TRANS_NONSEQ;
            end
        end
    end

    assign mem_HBURST    = BURST_SINGLE;
    assign mem_HMASTLOCK = 1'b0;
    assign mem_HWDATA    = (r_owner == OWNER_DAT) ? dat_HWDATA : ins_HWDATA;

    assign ins_HRDATA = mem_HRDATA;
    assign dat_HRDATA = mem_HRDATA;
    assign ins_HRESP  = !reset && (r_owner == OWNER_INS) && mem_HRESP;
    assign dat_HRESP  = !reset && (r_owner == OWNER_DAT) && mem_HRESP;

    // A live request that loses (or meets a stalled slave) is parked, since its master has moved on.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_insHoldValid <= 1'b0;
            r_datHoldValid <= 1'b0;
            r_owner        <= OWNER_NONE;
            r_lastGrantDat <= 1'b0;
        end else begin
            if (w_grantIns) begin
                r_insHoldValid <= 1'b0;
            end else if (w_insLive) begin
                r_insHoldValid <= 1'b1;
                r_insHoldAddr  <= ins_HADDR;
                r_insHoldWrite <= ins_HWRITE;
                r_insHoldSize  <= ins_HSIZE;
                r_insHoldProt  <= ins_HPROT;
            end

            if (w_grantDat) begin
                r_datHoldValid <= 1'b0;
            end else if (w_datLive) begin
                r_datHoldValid <= 1'b1;
                r_datHoldAddr  <= dat_HADDR;
                r_datHoldWrite <= dat_HWRITE;
                r_datHoldSize  <= dat_HSIZE;
                r_datHoldProt  <= dat_HPROT;
            end

            if (mem_HREADY) begin
                if (w_grantIns)
                    r_owner <= OWNER_INS;
                else if (w_grantDat)
                    r_owner <= OWNER_DAT;
                else
                    r_owner <= OWNER_NONE;
            end

            if (w_grantIns)
                r_lastGrantDat <= 1'b0;
            else if (w_grantDat)
                r_lastGrantDat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Scoreboard bench for ahb_master_arbiter: a round-robin instance plus a fixed-priority
// instance share stimulus; issued slave transfers are compared against an expected queue.
module tb_ahb_master_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
    } xfer_t;

    logic clock;
    logic reset;

    logic [31:0] insHaddr, datHaddr, insHwdata, datHwdata, memHrdata;
    logic [1:0]  insHtrans, datHtrans;
    logic        insHwrite, datHwrite, memHready, memHresp;
    logic [2:0]  insHsize, datHsize, insHburst, datHburst;
    logic [3:0]  insHprot, datHprot;

    logic [31:0] d0InsHrdata, d0DatHrdata, d0MemHaddr, d0MemHwdata;
    logic        d0InsHready, d0InsHresp, d0DatHready, d0DatHresp, d0MemHwrite, d0MemHmastlock;
    logic [1:0]  d0MemHtrans;
    logic [2:0]  d0MemHsize, d0MemHburst;
    logic [3:0]  d0MemHprot;

    logic [31:0] d1InsHrdata, d1DatHrdata, d1MemHaddr, d1MemHwdata;
    logic        d1InsHready, d1InsHresp, d1DatHready, d1DatHresp, d1MemHwrite, d1MemHmastlock;
    logic [1:0]  d1MemHtrans;
    logic [2:0]  d1MemHsize, d1MemHburst;
    logic [3:0]  d1MemHprot;

    int    checks = 0;
    int    errors = 0;
    xfer_t expQ[$];
    logic  monSel;
    xfer_t monExp;
    logic [31:0] monAddr;
    logic  monWrite;
    logic [1:0] monTrans;

    ahb_master_arbiter #(.ROUND_ROBIN(1), .ADDR_WIDTH(32)) dut0 (
        .clock(clock), .reset(reset),
        .ins_HADDR(insHaddr), .ins_HTRANS(insHtrans), .ins_HWRITE(insHwrite), .ins_HSIZE(insHsize),
        .ins_HBURST(insHburst), .ins_HPROT(insHprot), .ins_HWDATA(insHwdata),
        .ins_HRDATA(d0InsHrdata), .ins_HREADY(d0InsHready), .ins_HRESP(d0InsHresp),
        .dat_HADDR(datHaddr), .dat_HTRANS(datHtrans), .dat_HWRITE(datHwrite), .dat_HSIZE(datHsize),
        .dat_HBURST(datHburst), .dat_HPROT(datHprot), .dat_HWDATA(datHwdata),
        .dat_HRDATA(d0DatHrdata), .dat_HREADY(d0DatHready), .dat_HRESP(d0DatHresp),
        .mem_HADDR(d0MemHaddr), .mem_HTRANS(d0MemHtrans), .mem_HWRITE(d0MemHwrite), .mem_HSIZE(d0MemHsize),
        .mem_HBURST(d0MemHburst), .mem_HPROT(d0MemHprot), .mem_HWDATA(d0MemHwdata),
        .mem_HMASTLOCK(d0MemHmastlock), .mem_HRDATA(memHrdata), .mem_HREADY(memHready), .mem_HRESP(memHresp)
    );

    ahb_master_arbiter #(.ROUND_ROBIN(0), .ADDR_WIDTH(32)) dut1 (
        .clock(clock), .reset(reset),
        .ins_HADDR(insHaddr), .ins_HTRANS(insHtrans), .ins_HWRITE(insHwrite), .ins_HSIZE(insHsize),
        .ins_HBURST(insHburst), .ins_HPROT(insHprot), .ins_HWDATA(insHwdata),
        .ins_HRDATA(d1InsHrdata), .ins_HREADY(d1InsHready), .ins_HRESP(d1InsHresp),
        .dat_HADDR(datHaddr), .dat_HTRANS(datHtrans), .dat_HWRITE(datHwrite), .dat_HSIZE(datHsize),
        .dat_HBURST(datHburst), .dat_HPROT(datHprot), .dat_HWDATA(datHwdata),
        .dat_HRDATA(d1DatHrdata), .dat_HREADY(d1DatHready), .dat_HRESP(d1DatHresp),
        .mem_HADDR(d1MemHaddr), .mem_HTRANS(d1MemHtrans), .mem_HWRITE(d1MemHwrite), .mem_HSIZE(d1MemHsize),
        .mem_HBURST(d1MemHburst), .mem_HPROT(d1MemHprot), .mem_HWDATA(d1MemHwdata),
        .mem_HMASTLOCK(d1MemHmastlock), .mem_HRDATA(memHrdata), .mem_HREADY(memHready), .mem_HRESP(memHresp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every slave-accepted NONSEQ on the selected instance must match the head of the queue.
    always @(negedge clock) begin
        if (!reset) begin
            monAddr  = monSel ? d1MemHaddr  : d0MemHaddr;
            monWrite = monSel ? d1MemHwrite : d0MemHwrite;
            monTrans = monSel ? d1MemHtrans : d0MemHtrans;
            if (monTrans == 2'b10 && memHready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL bus_xfer unexpected addr=%0h write=%0b expected none", monAddr, monWrite);
                end else begin
                    monExp = expQ.pop_front();
                    if ({monAddr, monWrite} !== {monExp.addr, monExp.write}) begin
                        errors++;
                        $display("[TB] FAIL bus_xfer got addr=%0h write=%0b expected addr=%0h write=%0b",
                                 monAddr, monWrite, monExp.addr, monExp.write);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        insHtrans = 2'b00; datHtrans = 2'b00;
        insHaddr  = '0;    datHaddr  = '0;
        insHwrite = 1'b0;  datHwrite = 1'b0;
        insHsize  = 3'b010; datHsize = 3'b010;
        insHburst = 3'b001; datHburst = 3'b001;
        insHprot  = 4'b0011; datHprot = 4'b0011;
        insHwdata = '0;    datHwdata = '0;
        memHready = 1'b1;  memHresp  = 1'b0; memHrdata = '0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        idleInputs();
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic test_drained(input string name);
        checks++;
        if (expQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL %s_drained got %0d pending expected 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idleInputs();
        memHresp  = 1'b1;
        insHtrans = 2'b10;
        @(negedge clock);
        checks++; if (d0MemHtrans !== 2'b00) begin errors++; $display("[TB] FAIL reset_htrans got %0h expected 0", d0MemHtrans); end
        checks++; if (d0InsHready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ins_ready got %0b expected 1", d0InsHready); end
        checks++; if (d0DatHready !== 1'b1) begin errors++; $display("[TB] FAIL reset_dat_ready got %0b expected 1", d0DatHready); end
        checks++; if ({d0InsHresp, d0DatHresp} !== 2'b00) begin errors++; $display("[TB] FAIL reset_resp got %0b%0b expected 00", d0InsHresp, d0DatHresp); end
        nextCycle();
        reset = 1'b0;
        idleInputs();
        @(negedge clock);
        checks++; if (d0MemHtrans !== 2'b00) begin errors++; $display("[TB] FAIL post_reset_htrans got %0h expected 0", d0MemHtrans); end
        checks++; if (d0MemHmastlock !== 1'b0) begin errors++; $display("[TB] FAIL mastlock got %0b expected 0", d0MemHmastlock); end
        nextCycle();
    endtask

    task automatic test_uncontended();
        idleInputs();
        insHtrans = 2'b10; insHaddr = 32'h100;
        expQ.push_back({32'h100, 1'b0});
        @(negedge clock);
        checks++; if (d0MemHaddr !== 32'h100) begin errors++; $display("[TB] FAIL unc_addr got %0h expected 100", d0MemHaddr); end
        checks++; if (d0MemHtrans !== 2'b10) begin errors++; $display("[TB] FAIL unc_htrans got %0h expected 2", d0MemHtrans); end
        checks++; if (d0MemHburst !== 3'b000) begin errors++; $display("[TB] FAIL unc_burst got %0h expected 0", d0MemHburst); end
        nextCycle();
        insHtrans = 2'b00; memHrdata = 32'hCAFE0100;
        @(negedge clock);
        checks++; if (d0InsHready !== 1'b1) begin errors++; $display("[TB] FAIL unc_ready got %0b expected 1", d0InsHready); end
        checks++; if (d0InsHrdata !== 32'hCAFE0100) begin errors++; $display("[TB] FAIL unc_rdata got %0h expected cafe0100", d0InsHrdata); end
        nextCycle();
        test_drained("uncontended");
    endtask

    task automatic test_simultaneous();
        pulseReset();
        insHtrans = 2'b10; insHaddr = 32'h200;
        datHtrans = 2'b10; datHaddr = 32'h8000;
        expQ.push_back({32'h8000, 1'b0});
        expQ.push_back({32'h200, 1'b0});
        @(negedge clock);
        checks++; if (d0MemHaddr !== 32'h8000) begin errors++; $display("[TB] FAIL sim_first got %0h expected 8000", d0MemHaddr); end
        nextCycle();
        idleInputs();
        @(negedge clock);
        checks++; if (d0InsHready !== 1'b0) begin errors++; $display("[TB] FAIL sim_ins_held got %0b expected 0", d0InsHready); end
        checks++; if (d0MemHaddr !== 32'h200) begin errors++; $display("[TB] FAIL sim_second got %0h expected 200", d0MemHaddr); end
        nextCycle();
        @(negedge clock);
        checks++; if (d0InsHready !== 1'b1) begin errors++; $display("[TB] FAIL sim_ins_done got %0b expected 1", d0InsHready); end
        nextCycle();
        test_drained("simultaneous");
    endtask

    task automatic test_back_to_back();
        pulseReset();
        insHtrans = 2'b10; insHaddr = 32'h600;
        datHtrans = 2'b10; datHaddr = 32'hA000;
        expQ.push_back({32'hA000, 1'b0});
        @(negedge clock);
        checks++; if (d0MemHaddr !== 32'hA000) begin errors++; $display("[TB] FAIL b2b_first got %0h expected a000", d0MemHaddr); end
        nextCycle();
        insHtrans = 2'b00; datHaddr = 32'hA004;
        expQ.push_back({32'h600, 1'b0});
        expQ.push_back({32'hA004, 1'b0});
        @(negedge clock);
        checks++; if (d0MemHaddr !== 32'h600) begin errors++; $display("[TB] FAIL b2b_alt got %0h expected 600", d0MemHaddr); end
        checks++; if (d0DatHready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_dat_ready got %0b expected 1", d0DatHready); end
        nextCycle();
        datHtrans = 2'b00;
        @(negedge clock);
        checks++; if (d0MemHaddr !== 32'hA004) begin errors++; $display("[TB] FAIL b2b_dat_held got %0h expected a004", d0MemHaddr); end
        checks++; if ({d0DatHready, d0InsHready} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_readies got %0b%0b expected 01", d0DatHready, d0InsHready); end
        nextCycle();
        @(negedge clock);
        checks++; if (d0DatHready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_dat_done got %0b expected 1", d0DatHready); end
        nextCycle();
        test_drained("back_to_back");
    endtask

    task automatic test_slave_wait();
        idleInputs();
        nextCycle();
        datHtrans = 2'b10; datHaddr = 32'h10; datHwrite = 1'b1;
        expQ.push_back({32'h10, 1'b1});
        @(negedge clock);
        checks++; if ({d0MemHaddr, d0MemHwrite} !== {32'h10, 1'b1}) begin errors++; $display("[TB] FAIL wait_dat_addr got %0h/%0b expected 10/1", d0MemHaddr, d0MemHwrite); end
        nextCycle();
        datHtrans = 2'b00; datHwdata = 32'hD0D00010; memHready = 1'b0;
        insHtrans = 2'b10; insHaddr = 32'h300;
        expQ.push_back({32'h300, 1'b0});
        @(negedge clock);
        checks++; if (d0DatHready !== 1'b0) begin errors++; $display("[TB] FAIL wait1_dat_ready got %0b expected 0", d0DatHready); end
        checks++; if (d0MemHwdata !== 32'hD0D00010) begin errors++; $display("[TB] FAIL wait_wdata got %0h expected d0d00010", d0MemHwdata); end
        checks++; if (d0InsHready !== 1'b1) begin errors++; $display("[TB] FAIL wait1_ins_ready got %0b expected 1", d0InsHready); end
        nextCycle();
        insHtrans = 2'b00;
        @(negedge clock);
        checks++; if (d0DatHready !== 1'b0) begin errors++; $display("[TB] FAIL wait2_dat_ready got %0b expected 0", d0DatHready); end
        checks++; if ({d0MemHtrans, d0MemHaddr} !== {2'b10, 32'h300}) begin errors++; $display("[TB] FAIL wait2_held got %0h/%0h expected 2/300", d0MemHtrans, d0MemHaddr); end
        checks++; if (d0InsHready !== 1'b0) begin errors++; $display("[TB] FAIL wait2_ins_ready got %0b expected 0", d0InsHready); end
        nextCycle();
        memHready = 1'b1;
        @(negedge clock);
        checks++; if (d0DatHready !== 1'b1) begin errors++; $display("[TB] FAIL wait3_dat_ready got %0b expected 1", d0DatHready); end
        checks++; if (d0MemHaddr !== 32'h300) begin errors++; $display("[TB] FAIL wait3_addr got %0h expected 300", d0MemHaddr); end
        nextCycle();
        @(negedge clock);
        checks++; if (d0InsHready !== 1'b1) begin errors++; $display("[TB] FAIL wait4_ins_ready got %0b expected 1", d0InsHready); end
        nextCycle();
        test_drained("slave_wait");
    endtask

    task automatic test_error();
        idleInputs();
        insHtrans = 2'b10; insHaddr = 32'h400;
        expQ.push_back({32'h400, 1'b0});
        @(negedge clock);
        checks++; if (d0MemHaddr !== 32'h400) begin errors++; $display("[TB] FAIL err_addr got %0h expected 400", d0MemHaddr); end
        nextCycle();
        insHtrans = 2'b00; memHready = 1'b0; memHresp = 1'b1;
        @(negedge clock);
        checks++; if ({d0InsHresp, d0DatHresp, d0InsHready} !== 3'b100) begin errors++; $display("[TB] FAIL err1 got resp=%0b%0b rdy=%0b expected 10/0", d0InsHresp, d0DatHresp, d0InsHready); end
        nextCycle();
        memHready = 1'b1;
        @(negedge clock);
        checks++; if ({d0InsHresp, d0DatHresp, d0InsHready} !== 3'b101) begin errors++; $display("[TB] FAIL err2 got resp=%0b%0b rdy=%0b expected 10/1", d0InsHresp, d0DatHresp, d0InsHready); end
        nextCycle();
        memHresp = 1'b0;
        @(negedge clock);
        checks++; if (d0InsHresp !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got %0b expected 0", d0InsHresp); end
        nextCycle();
        test_drained("error");
    endtask

    task automatic test_fixed_priority();
        monSel = 1'b1;
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] expAddr;
            logic        expRdy;
            expAddr = 32'h9000 + 32'(4 * i);
            expRdy  = (i == 0);
            insHtrans = 2'b10; insHaddr = 32'h500;
            datHtrans = 2'b10; datHaddr = expAddr;
            expQ.push_back({expAddr, 1'b0});
            @(negedge clock);
            checks++; if (d1MemHaddr !== expAddr) begin errors++; $display("[TB] FAIL fixed_grant%0d got %0h expected %0h", i, d1MemHaddr, expAddr); end
            checks++; if (d1InsHready !== expRdy) begin errors++; $display("[TB] FAIL fixed_ins_ready%0d got %0b expected %0b", i, d1InsHready, expRdy); end
            nextCycle();
        end
        idleInputs();
        expQ.push_back({32'h500, 1'b0});
        @(negedge clock);
        checks++; if (d1MemHaddr !== 32'h500) begin errors++; $display("[TB] FAIL fixed_ins_late got %0h expected 500", d1MemHaddr); end
        nextCycle();
        @(negedge clock);
        checks++; if (d1InsHready !== 1'b1) begin errors++; $display("[TB] FAIL fixed_ins_done got %0b expected 1", d1InsHready); end
        nextCycle();
        test_drained("fixed_priority");
        monSel = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulseReset();
        insHtrans = 2'b10; insHaddr = 32'h200;
        datHtrans = 2'b10; datHaddr = 32'h8000;
        expQ.push_back({32'h8000, 1'b0});
        @(negedge clock);
        checks++; if (d0MemHaddr !== 32'h8000) begin errors++; $display("[TB] FAIL rmid_first got %0h expected 8000", d0MemHaddr); end
        nextCycle();
        reset = 1'b1;
        idleInputs();
        @(negedge clock);
        checks++; if ({d0InsHready, d0MemHtrans} !== 3'b100) begin errors++; $display("[TB] FAIL rmid_in_reset got rdy=%0b trans=%0h expected 1/0", d0InsHready, d0MemHtrans); end
        nextCycle();
        reset = 1'b0;
        @(negedge clock);
        checks++; if ({d0InsHready, d0MemHtrans} !== 3'b100) begin errors++; $display("[TB] FAIL rmid_after got rdy=%0b trans=%0h expected 1/0", d0InsHready, d0MemHtrans); end
        nextCycle();
        @(negedge clock);
        checks++; if (d0MemHtrans !== 2'b00) begin errors++; $display("[TB] FAIL rmid_no_issue got %0h expected 0", d0MemHtrans); end
        nextCycle();
        test_drained("reset_mid");
    endtask

    initial begin
        monSel = 1'b0;
        reset  = 1'b1;
        idleInputs();
        test_reset();
        test_uncontended();
        test_simultaneous();
        test_back_to_back();
        test_slave_wait();
        test_error();
        test_fixed_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
